controle_irrigacao: RTL and testbench

CONTROLE_IRRIGACAO -- requirements
Module: controle_irrigacao

---
 rtl/irriga_pkg.sv | 42 ++++
 rtl/detector_borda.sv | 25 ++
 rtl/controle_irrigacao.sv | 105 ++++++++++
 tb/tb_controle_irrigacao.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/irriga_pkg.sv
// Shared definitions for the irrigation controller: state encoding, tens preset
// limit and the Moore output decode used by controle_irrigacao.
package irriga_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    PAUSA = 3'd3,
    DONE  = 3'd4
  } estado_t;

  localparam logic [3:0] DEZ_MAX = 4'd9;
  localparam logic [3:0] UNID_MAX = 4'd9;

  typedef struct packed {
    logic carga;
    logic hab_contagem;
    logic valvula;
    logic fim;
  } saidas_t;

  function automatic logic [3:0] clamp_dez(input logic [3:0] valor);
    return (valor > DEZ_MAX) ? DEZ_MAX : valor;
  endfunction

  function automatic saidas_t decode_saidas(input estado_t estado);
    saidas_t s;
    s = '0;
    case (estado)
      LOAD:    s.carga = 1'b1;
      RUN:     begin
        s.hab_contagem = 1'b1;
        s.valvula      = 1'b1;
      end
      DONE:    s.fim = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector for a level input; a level already high when reset is
// released is not reported as an edge.
module detector_borda (
  input  logic clockin,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  // armado means "input was seen low last cycle"; clearing it in reset masks a
  // level that is already high at release.
  logic armado;

  always_ff @(posedge clockin or posedge reset) begin
    if (reset) begin
      armado <= 1'b0;
    end else begin
      // NOTE: non-blocking for all sequential state so every flop samples pre-edge values.
      armado <= ~in;
    end
  end

  assign pulse = in & armado;

endmodule

// File: rtl/controle_irrigacao.sv
// Irrigation timer controller: loads a BCD tens preset, counts it down with
// borrows from an upstream units counter and drives the valve while running.
// Define IRRIGA_SENSOR_EN to enable the soil-moisture pause (PAUSA state).
module controle_irrigacao
  import irriga_pkg::*;
(
  input  logic       clockin,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] tempo_dez,
  input  logic [3:0] unid_q,
  input  logic       tick,
  input  logic       umidade,
  output logic       carga,
  output logic       hab_contagem,
  output logic       valvula,
  output logic [3:0] dez_q,
  output logic [2:0] estado,
  output logic       fim
);

  estado_t    estado_r;
  estado_t    estado_nxt;
  logic [3:0] dez_nxt;
  logic [3:0] unid_ant;
  logic       borda;
  logic       borrow;
  saidas_t    saidas_nxt;

  detector_borda u_borda (
    .clockin (clockin),
    .reset   (reset),
    .in      (iniciar),
    .pulse   (borda)
  );

`ifndef IRRIGA_SENSOR_EN
  logic unused_umidade;
  assign unused_umidade = umidade;
`endif

  // A tens borrow is the units digit wrapping from 0 to 9.
  assign borrow = tick && (unid_q == UNID_MAX) && (unid_ant == 4'd0);

  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    estado_nxt = estado_r;
    dez_nxt    = dez_q;
    case (estado_r)
      IDLE:  if (borda) estado_nxt = LOAD;
      LOAD:  begin
        dez_nxt    = clamp_dez(tempo_dez);
        estado_nxt = RUN;
      end
      RUN:   begin
        if (borda) begin
          estado_nxt = IDLE;
        end else if (unid_q == 4'd0 && dez_q == 4'd0) begin
          estado_nxt = DONE;
        end else begin
          if (borrow && dez_q != 4'd0) dez_nxt = dez_q - 4'd1;
`ifdef IRRIGA_SENSOR_EN
          if (umidade) estado_nxt = PAUSA;
`endif
        end
      end
      PAUSA: begin
`ifdef IRRIGA_SENSOR_EN
        if (borda)         estado_nxt = IDLE;
        else if (!umidade) estado_nxt = RUN;
`else
        estado_nxt = IDLE;
`endif
      end
      DONE:    estado_nxt = IDLE;
      default: estado_nxt = IDLE;
    endcase
  end

  assign saidas_nxt = decode_saidas(estado_nxt);

  // Outputs are registered from the next state, so they always match estado_r.
  always_ff @(posedge clockin or posedge reset) begin
    if (reset) begin
      estado_r     <= IDLE;
      dez_q        <= 4'd0;
      unid_ant     <= 4'd0;
      carga        <= 1'b0;
      hab_contagem <= 1'b0;
      valvula      <= 1'b0;
      fim          <= 1'b0;
    end else begin
      estado_r     <= estado_nxt;
      dez_q        <= dez_nxt;
      if (tick) unid_ant <= unid_q;
      carga        <= saidas_nxt.carga;
      hab_contagem <= saidas_nxt.hab_contagem;
      valvula      <= saidas_nxt.valvula;
      fim          <= saidas_nxt.fim;
    end
  end

  assign estado = estado_r;

endmodule

// File: tb/tb_controle_irrigacao.sv
// Directed bench for controle_irrigacao: countdown, zero preset, clamp, abort,
// moisture pause (with or without IRRIGA_SENSOR_EN) and asynchronous reset.
module tb_controle_irrigacao;

  logic       clockin;
  logic       reset;
  logic       iniciar;
  logic [3:0] tempo_dez;
  logic [3:0] unid_q;
  logic       tick;
  logic       umidade;
  logic       carga;
  logic       hab_contagem;
  logic       valvula;
  logic [3:0] dez_q;
  logic [2:0] estado;
  logic       fim;

  int n_pass  = 0;
  int n_total = 0;

  controle_irrigacao dut (
    .clockin      (clockin),
    .reset        (reset),
    .iniciar      (iniciar),
    .tempo_dez    (tempo_dez),
    .unid_q       (unid_q),
    .tick         (tick),
    .umidade      (umidade),
    .carga        (carga),
    .hab_contagem (hab_contagem),
    .valvula      (valvula),
    .dez_q        (dez_q),
    .estado       (estado),
    .fim          (fim)
  );

  initial begin
    clockin = 1'b0;
    forever #5 clockin = ~clockin;
  end

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Advance one clock; inputs and checks happen 1 time unit after the edge.
  task automatic step();
    @(posedge clockin);
    #1;
  endtask

  task automatic pulse_tick(input logic [3:0] v);
    unid_q = v;
    tick   = 1'b1;
    step();
    tick   = 1'b0;
    step();
  endtask

  initial begin
    reset     = 1'b0;
    iniciar   = 1'b0;
    tempo_dez = 4'd0;
    unid_q    = 4'd0;
    tick      = 1'b0;
    umidade   = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("rst_estado", 8'(estado), 8'd0);
    check("rst_valvula", 8'(valvula), 8'd0);
    check("rst_dez", 8'(dez_q), 8'd0);
    check("rst_carga_fim", 8'({carga, hab_contagem, fim}), 8'd0);
    #19 reset = 1'b0;
    step();

    // Countdown from tens preset 2 with units ticks 5..0, 9..0, 9..0
    tempo_dez = 4'd2;
    unid_q    = 4'd5;
    iniciar   = 1'b1;
    step();
    check("cnt_load_estado", 8'(estado), 8'd1);
    check("cnt_load_carga", 8'(carga), 8'd1);
    check("cnt_load_valvula", 8'(valvula), 8'd0);
    iniciar = 1'b0;
    step();
    check("cnt_run_estado", 8'(estado), 8'd2);
    check("cnt_run_carga", 8'(carga), 8'd0);
    check("cnt_run_outs", 8'({valvula, hab_contagem}), 8'b11);
    check("cnt_run_dez", 8'(dez_q), 8'd2);
    for (int v = 5; v >= 0; v--) pulse_tick(4'(v));
    check("cnt_unid0_dez2", 8'(dez_q), 8'd2);
    check("cnt_unid0_estado", 8'(estado), 8'd2);
    pulse_tick(4'd9);
    check("cnt_borrow1", 8'(dez_q), 8'd1);
    for (int v = 8; v >= 0; v--) pulse_tick(4'(v));
    check("cnt_pre_borrow2", 8'(dez_q), 8'd1);
    pulse_tick(4'd9);
    check("cnt_borrow2", 8'(dez_q), 8'd0);
    for (int v = 8; v >= 1; v--) pulse_tick(4'(v));
    check("cnt_still_run", 8'(estado), 8'd2);
    unid_q = 4'd0;
    tick   = 1'b1;
    step();
    tick = 1'b0;
    check("cnt_done_estado", 8'(estado), 8'd4);
    check("cnt_done_fim", 8'(fim), 8'd1);
    check("cnt_done_valvula", 8'(valvula), 8'd0);
    step();
    check("cnt_idle_estado", 8'(estado), 8'd0);
    check("cnt_idle_fim", 8'(fim), 8'd0);
    check("cnt_idle_valvula", 8'(valvula), 8'd0);

    // Zero preset: estado 0,1,2,4,0
    tempo_dez = 4'd0;
    unid_q    = 4'd0;
    check("zero_c1", 8'(estado), 8'd0);
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    check("zero_c2", 8'(estado), 8'd1);
    step();
    check("zero_c3", 8'(estado), 8'd2);
    check("zero_c3_fim", 8'(fim), 8'd0);
    step();
    check("zero_c4", 8'(estado), 8'd4);
    check("zero_c4_fim", 8'(fim), 8'd1);
    step();
    check("zero_c5", 8'(estado), 8'd0);
    check("zero_c5_fim", 8'(fim), 8'd0);

    // Clamp of preset 12 to 9, then abort holds dez_q
    tempo_dez = 4'd12;
    unid_q    = 4'd5;
    iniciar   = 1'b1;
    step();
    iniciar = 1'b0;
    step();
    check("clamp_dez", 8'(dez_q), 8'd9);
    check("clamp_estado", 8'(estado), 8'd2);
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    check("clamp_abort_estado", 8'(estado), 8'd0);
    check("clamp_abort_dez", 8'(dez_q), 8'd9);
    step();

    // Abort in RUN with dez_q=4
    tempo_dez = 4'd4;
    iniciar   = 1'b1;
    step();
    iniciar = 1'b0;
    step();
    check("abort_pre_dez", 8'(dez_q), 8'd4);
    iniciar = 1'b1;
    step();
    check("abort_estado", 8'(estado), 8'd0);
    check("abort_fim", 8'(fim), 8'd0);
    check("abort_valvula", 8'(valvula), 8'd0);
    check("abort_dez", 8'(dez_q), 8'd4);
    iniciar = 1'b0;
    step();
    check("abort_stays_idle", 8'({estado, fim}), 8'd0);

    // Moisture: pause with sensor enabled, ignored otherwise
    tempo_dez = 4'd3;
    unid_q    = 4'd5;
    iniciar   = 1'b1;
    step();
    iniciar = 1'b0;
    step();
    check("hum_run_dez", 8'(dez_q), 8'd3);
    umidade = 1'b1;
    step();
`ifdef IRRIGA_SENSOR_EN
    check("hum_pausa_estado", 8'(estado), 8'd3);
    check("hum_pausa_valvula", 8'(valvula), 8'd0);
    pulse_tick(4'd0);
    pulse_tick(4'd9);
    check("hum_pausa_estado2", 8'(estado), 8'd3);
    check("hum_pausa_dez", 8'(dez_q), 8'd3);
    umidade = 1'b0;
    step();
    check("hum_resume_estado", 8'(estado), 8'd2);
    check("hum_resume_valvula", 8'(valvula), 8'd1);
    check("hum_resume_dez", 8'(dez_q), 8'd3);
`else
    check("hum_ignored_estado", 8'(estado), 8'd2);
    check("hum_ignored_valvula", 8'(valvula), 8'd1);
    pulse_tick(4'd0);
    pulse_tick(4'd9);
    check("hum_ignored_borrow", 8'(dez_q), 8'd2);
    umidade = 1'b0;
    step();
    check("hum_ignored_run", 8'(estado), 8'd2);
`endif

    // Asynchronous reset mid-RUN, then iniciar held across release
    #2 reset = 1'b1;
    #1;
    check("arst_valvula", 8'(valvula), 8'd0);
    check("arst_estado", 8'(estado), 8'd0);
    check("arst_fim", 8'(fim), 8'd0);
    check("arst_dez", 8'(dez_q), 8'd0);
    iniciar = 1'b1;
    step();
    #2 reset = 1'b0;
    step();
    step();
    check("held_no_load_estado", 8'(estado), 8'd0);
    check("held_no_load_carga", 8'(carga), 8'd0);
    iniciar = 1'b0;
    step();
    iniciar = 1'b1;
    step();
    check("fresh_edge_load", 8'(estado), 8'd1);
    iniciar = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
